// File: rtl/prom_fetch.sv
// Instruction fetch stage: owns the PC, drives the combinational program ROM and
// buffers {pc, word} pairs in a 2-entry FIFO toward the decoder via valid/ready.
module prom_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [1:0]        level
);

    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        r_level;
    logic [DATA_W-1:0] r_word [2];
    logic [ADDR_W-1:0] r_tag  [2];

    logic w_pop;
    logic w_push;

    assign w_pop    = (r_level != 2'd0) && instr_ready;
    assign w_push   = run && !branch_valid && ((r_level != 2'd2) || w_pop);
    assign rom_addr = r_pc;

    // Slot 0 is always the head; slot 1 only holds a word when level is 2.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc     <= RESET_PC;
            r_level  <= 2'd0;
            r_word[0] <= '0;
            r_word[1] <= '0;
            r_tag[0]  <= '0;
            r_tag[1]  <= '0;
        end else if (branch_valid) begin
            r_pc    <= branch_target;
            r_level <= 2'd0;
        end else begin
            if (w_push) begin
                r_pc <= r_pc + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b11: begin
                    if (r_level == 2'd2) begin
                        r_word[0] <= r_word[1];
                        r_tag[0]  <= r_tag[1];
                        r_word[1] <= rom_data;
                        r_tag[1]  <= r_pc;
                    end else begin
                        r_word[0] <= rom_data;
                        r_tag[0]  <= r_pc;
                    end
                end
                2'b01: begin
                    r_word[0] <= r_word[1];
                    r_tag[0]  <= r_tag[1];
                    r_level   <= r_level - 2'd1;
                end
                2'b10: begin
                    if (r_level == 2'd0) begin
                        r_word[0] <= rom_data;
                        r_tag[0]  <= r_pc;
                    end else begin
                        r_word[1] <= rom_data;
                        r_tag[1]  <= r_pc;
                    end
                    r_level <= r_level + 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign instr_valid = (r_level != 2'd0);
    assign instr_data  = r_word[0];
    assign instr_pc    = r_tag[0];
    assign level       = r_level;

endmodule

// File: tb/tb_prom_fetch.sv
// Bench for prom_fetch: a driver updates a reference model and a scoreboard queue,
// a separate monitor checks every accepted word plus level/valid/rom_addr each cycle.
module tb_prom_fetch;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        run = 1'b0;
    logic        branch_valid = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        instr_ready = 1'b0;

    logic [15:0] rom_addr0, rom_addr1;
    logic [31:0] rom_data0, rom_data1;
    logic        instr_valid0, instr_valid1;
    logic [31:0] instr_data0, instr_data1;
    logic [15:0] instr_pc0, instr_pc1;
    logic [1:0]  level0, level1;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rom_fn(input logic [15:0] a);
        case (a)
            16'h0000: rom_fn = 32'h00080007;
            16'h0001: rom_fn = 32'h04000008;
            16'h0002: rom_fn = 32'h00002005;
            16'h000A: rom_fn = 32'h00080043;
            default:  rom_fn = {16'hC0DE, a};
        endcase
    endfunction

    assign rom_data0 = rom_fn(rom_addr0);
    assign rom_data1 = rom_fn(rom_addr1);

    prom_fetch #(.ADDR_W(16), .DATA_W(32), .RESET_PC(16'h0000)) dut0 (
        .CLK(CLK), .RST(RST), .run(run),
        .rom_addr(rom_addr0), .rom_data(rom_data0),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .instr_valid(instr_valid0), .instr_ready(instr_ready),
        .instr_data(instr_data0), .instr_pc(instr_pc0), .level(level0)
    );

    prom_fetch #(.ADDR_W(16), .DATA_W(32), .RESET_PC(16'hFFFF)) dut1 (
        .CLK(CLK), .RST(RST), .run(run),
        .rom_addr(rom_addr1), .rom_data(rom_data1),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .instr_valid(instr_valid1), .instr_ready(instr_ready),
        .instr_data(instr_data1), .instr_pc(instr_pc1), .level(level1)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    logic [47:0] sb[$];     // {pc, word} expected in delivery order for dut0
    logic [15:0] m_pc, m_pc_n;
    int          m_lvl, m_lvl_n;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock cycle: advance the model, drive inputs, compute next model state.
    task automatic step(input bit r, input bit ru, input bit rd, input bit bv, input logic [15:0] bt);
        bit p_pop, p_push;
        @(posedge CLK);
        m_pc  = m_pc_n;
        m_lvl = m_lvl_n;
        #2;
        RST = r; run = ru; instr_ready = rd; branch_valid = bv; branch_target = bt;
        if (r) begin
            m_pc_n  = 16'h0000;
            m_lvl_n = 0;
            sb.delete();
        end else begin
            p_pop  = (m_lvl != 0) && rd;
            p_push = ru && !bv && ((m_lvl < 2) || p_pop);
            if (bv) begin
                m_pc_n  = bt;
                m_lvl_n = 0;
                while (sb.size() > (p_pop ? 1 : 0)) void'(sb.pop_back());
            end else begin
                if (p_push) begin
                    sb.push_back({m_pc, rom_fn(m_pc)});
                    m_pc_n = m_pc + 16'd1;
                end else begin
                    m_pc_n = m_pc;
                end
                m_lvl_n = m_lvl + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
            end
        end
        $display("cycle t=%0t rst=%0b run=%0b rdy=%0b br=%0b tgt=%h model_pc=%h model_lvl=%0d",
                 $time, r, ru, rd, bv, bt, m_pc, m_lvl);
    endtask

    // Monitor: per-cycle state checks and scoreboard pop on each accepted word.
    initial begin
        logic [47:0] e;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                chk("level", 64'(level0), 64'(m_lvl));
                chk("valid", 64'(instr_valid0), 64'(m_lvl != 0));
                chk("rom_addr", 64'(rom_addr0), 64'(m_pc));
                if (!RST && instr_valid0 && instr_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL accept: got pc=%h data=%h expected no word", instr_pc0, instr_data0);
                    end else begin
                        e = sb.pop_front();
                        chk("accept_pc", 64'(instr_pc0), 64'(e[47:32]));
                        chk("accept_data", 64'(instr_data0), 64'(e[31:0]));
                        $display("accept pc=%h data=%h", instr_pc0, instr_data0);
                    end
                end
            end
        end
    end

    initial begin
        m_pc_n  = 16'h0000;
        m_lvl_n = 0;

        // Reset values
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        @(negedge CLK); #1;
        chk("rst_valid", 64'(instr_valid0), 64'd0);
        chk("rst_data", 64'(instr_data0), 64'd0);
        chk("rst_pc", 64'(instr_pc0), 64'd0);
        chk("rst_level", 64'(level0), 64'd0);
        chk("rst_addr", 64'(rom_addr0), 64'h0000);
        chk("rst_addr_ffff", 64'(rom_addr1), 64'hFFFF);
        mon_en = 1'b1;

        // Streaming with ready high; dut1 checks the FFFF -> 0000 wrap
        step(0, 1, 1, 0, 16'h0);
        step(0, 1, 1, 0, 16'h0);
        @(negedge CLK); #1;
        chk("c1_data", 64'(instr_data0), 64'h00080007);
        chk("c1_pc", 64'(instr_pc0), 64'h0000);
        chk("wrap1_pc", 64'(instr_pc1), 64'hFFFF);
        chk("wrap1_data", 64'(instr_data1), 64'hC0DEFFFF);
        step(0, 1, 1, 0, 16'h0);
        @(negedge CLK); #1;
        chk("c2_data", 64'(instr_data0), 64'h04000008);
        chk("wrap2_pc", 64'(instr_pc1), 64'h0000);
        chk("wrap2_data", 64'(instr_data1), 64'h00080007);
        step(0, 1, 1, 0, 16'h0);
        @(negedge CLK); #1;
        chk("c3_data", 64'(instr_data0), 64'h00002005);
        chk("c3_pc", 64'(instr_pc0), 64'h0002);

        // Backpressure
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 16'h0);
        @(negedge CLK); #1;
        chk("bp_level", 64'(level0), 64'd2);
        chk("bp_addr", 64'(rom_addr0), 64'h0002);
        chk("bp_head", 64'(instr_data0), 64'h00080007);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 16'h0);

        // Branch with a full buffer
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 0, 1, 16'h000A);
        step(0, 1, 1, 0, 16'h0);
        @(negedge CLK); #1;
        chk("br_level", 64'(level0), 64'd0);
        chk("br_valid", 64'(instr_valid0), 64'd0);
        chk("br_addr", 64'(rom_addr0), 64'h000A);
        step(0, 1, 1, 0, 16'h0);
        @(negedge CLK); #1;
        chk("br_data", 64'(instr_data0), 64'h00080043);
        chk("br_pc", 64'(instr_pc0), 64'h000A);

        // run low drains the buffer and holds the PC
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 1, 0, 16'h0);
        @(negedge CLK); #1;
        chk("runlo_level", 64'(level0), 64'd0);
        chk("runlo_addr", 64'(rom_addr0), 64'h000C);
        step(0, 1, 1, 0, 16'h0);
        step(0, 1, 1, 0, 16'h0);
        @(negedge CLK); #1;
        chk("resume_pc", 64'(instr_pc0), 64'h000C);

        // Reset with level 2 and PC 7
        step(0, 1, 0, 1, 16'h0005);
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0);
        step(0, 1, 0, 0, 16'h0);
        @(negedge CLK); #1;
        chk("pre_rst_level", 64'(level0), 64'd2);
        chk("pre_rst_addr", 64'(rom_addr0), 64'h0007);
        step(1, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 16'h0);
        @(negedge CLK); #1;
        chk("mid_rst_valid", 64'(instr_valid0), 64'd0);
        chk("mid_rst_level", 64'(level0), 64'd0);
        chk("mid_rst_addr", 64'(rom_addr0), 64'h0000);
        step(0, 1, 1, 0, 16'h0);
        step(0, 1, 1, 0, 16'h0);
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 1, 0, 16'h0);
        step(0, 0, 1, 0, 16'h0);
        @(negedge CLK); #1;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
